cpc_romctrl: RTL and testbench
==============================

# cpc_romctrl

Single-clock controller for the eight-slot CPC ROM board, intended for the CPLD build. It latches the upper-ROM select byte from Z80 I/O writes and decodes it into four pair chip-selects, ROM_A14 and ROMDIS. It also sequences in-circuit byte writes to the 28C256 EEPROMs: it generates the WE pulse, stretches the Z80 cycle through READY, and blocks further writes for the EEPROM internal write time.

## Interface
- TWC_CYCLES, 40000: EEPROM write-cycle hold-off in CLK cycles (10 ms at 4 MHz).
- WE_CYCLES, 2: WE_B low pulse width in CLK cycles, ≥1.
- CLK  in  1  CPC bus clock, rising-edge. One clock only.
- RESET_B  in  1  Asynchronous, active-low reset.
- A15, A14, A13, A8  in  1 each  Z80 address bits.
- D  in  8  Z80 data bus, sampled on I/O writes.
- IOREQ_B, MREQ_B, WR_B, ROMEN_B  in  1 each  Z80/gate-array strobes, active-low.
- BANK  in  1  Board bank jumper. Slots 0–7 respond when q[3]==BANK.
- SLOT_EN  in  8  Per-slot enable straps; 1 = slot populated.
- ROMCS_B  out  4  Pair chip-selects for slots 01, 23, 45, 67; active-low.
- ROM_A14  out  1  Odd/even slot within the pair; equals the latched q[0].
- ROMDIS  out  1  Disables the internal ROM; high while a local slot is selected.
- ROM_WE_B  out  1  Common EEPROM write enable, active-low.
- READY_PULL  out  1  1 = drive the CPC READY (WAIT) line low.
- BUSY  out  1  EEPROM write cycle in progress.

## Operation
- All inputs are sampled on the rising CLK edge. io_wr = !IOREQ_B & !WR_B & !A13. Register writes fire on the first cycle io_wr is seen (rising-edge detect).
  - A8=1 (port &DFxx): sel <= D.
  - A8=0 (port &DExx): wen <= D[0]. All other bits are ignored.
- hit = sel[7:4]==0 & sel[3]==BANK & SLOT_EN[sel[2:0]].
- ROMDIS = hit, registered.
- ROMCS_B[sel[2:1]] = 0 when hit & A14 & (!ROMEN_B | wr_active); otherwise 1.
- ROM_A14 = sel[0].
- A ROM write request is mem_wr = !MREQ_B & !WR_B & A15 & A14 & hit & wen, rising-edge detected. Requests with wen=0 or !hit are ignored; the CPC RAM underneath still takes the write.
- Write FSM states: IDLE, STALL, WE, HOLD.
  - IDLE: on mem_wr, go to WE and set READY_PULL=1.
  - WE: ROM_WE_B=0 and READY_PULL=1 for WE_CYCLES cycles. Then ROM_WE_B=1, READY_PULL=0, and load cnt=TWC_CYCLES-1; go to HOLD.
  - HOLD: BUSY=1. cnt decrements each cycle; at cnt==0 go to IDLE. A mem_wr seen in HOLD goes to STALL.
  - STALL: READY_PULL=1 (Z80 frozen, WR/data held). When cnt reaches 0, go straight to WE; IDLE is skipped.
- wr_active = state ∈ {WE}. The slot targeted is the sel value current at WE entry.
- sel writes are accepted in any state. A change of sel during HOLD/STALL does not affect the running EEPROM cycle. A STALLed write goes to the new sel if hit still holds; otherwise the FSM goes to IDLE and releases READY.
- Simultaneous io_wr and mem_wr in the same cycle cannot occur on the Z80 bus. If both are seen, io_wr is processed and mem_wr is ignored.

## Timing
- Reset values: sel=0, wen=0, state=IDLE, cnt=0, ROMCS_B=4'hF, ROM_A14=0, ROMDIS=0, ROM_WE_B=1, READY_PULL=0, BUSY=0.
- Reset mid-operation: ROM_WE_B and READY_PULL go inactive immediately (asynchronous). Software must wait a further 10 ms before the next write.
- Latency:
  - sel/wen update 1 cycle after io_wr is detected; ROMDIS follows 1 cycle later.
  - READY_PULL and ROM_WE_B both assert 1 cycle after mem_wr is detected.
  - WE_B low for exactly WE_CYCLES cycles.
  - BUSY high for exactly TWC_CYCLES cycles after WE_B rises.
- cnt width is $clog2(TWC_CYCLES). The counter never wraps: it holds at 0 in IDLE.

## Structure
- Package cpc_romctrl_pkg holds:
  - the state enum {IDLE, STALL, WE, HOLD};
  - port constants SEL_PORT_A8=1 and CTL_PORT_A8=0;
  - default TWC_CYCLES and WE_CYCLES.
- One sub-module, eeprom_wr_seq: the FSM plus cnt, with inputs mem_wr_pulse and hit and outputs ROM_WE_B, READY_PULL, BUSY, wr_active. Decode and registers stay in the top level.

## Test plan
- Reset, then I/O write &DF00 with D=8'h05, BANK=0, SLOT_EN=8'hFF, A14=1, ROMEN_B=0 -> ROMCS_B=4'b1011, ROM_A14=1, ROMDIS=1.
- sel=8'h15, or sel=8'h0D with BANK=0, or SLOT_EN[5]=0 -> ROMCS_B=4'hF, ROMDIS=0.
- wen=0, memory write to &C000 -> ROM_WE_B stays 1 and READY_PULL stays 0.
- wen=1 (OUT &DE00,1), write to &C123 with TWC_CYCLES=16 -> READY_PULL and WE_B low for 2 cycles, then BUSY high for exactly 16 cycles.
- Second write 3 cycles into HOLD -> READY_PULL high until cnt==0, then a WE pulse with no IDLE cycle between.
- RESET_B low during WE -> ROM_WE_B=1 and READY_PULL=0 before the next CLK edge; all outputs at reset values.

Source files
------------

// File: rtl/cpc_romctrl_pkg.sv
// Shared types and constants for the CPC upper-ROM board controller.
package cpc_romctrl_pkg;

  // EEPROM write sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    WE    = 2'd2,
    HOLD  = 2'd3
  } wr_state_e;

  // A8 value that selects each I/O port: &DFxx = ROM select, &DExx = control.
  localparam logic SEL_PORT_A8 = 1'b1;
  localparam logic CTL_PORT_A8 = 1'b0;

  // 10 ms EEPROM write time at a 4 MHz bus clock, and the WE_B low width.
  localparam int TWC_CYCLES_DEF = 40000;
  localparam int WE_CYCLES_DEF  = 2;

  // A select byte addresses a populated local slot on this board's bank.
  function automatic logic slot_hit(input logic [7:0] sel, input logic bank,
                                    input logic [7:0] slot_en);
    return (sel[7:4] == 4'h0) && (sel[3] == bank) && slot_en[sel[2:0]];
  endfunction

endpackage

// File: rtl/cpc_romctrl_if.sv
// Z80 / gate-array bus and ROM board outputs seen by the controller.
// All strobes are active-low; the controller samples every input on the
// rising CLK edge and has no valid/ready handshake of its own -- the CPU is
// held off by READY_PULL while an EEPROM write is in progress.
interface cpc_romctrl_if;
  import cpc_romctrl_pkg::*;

  logic       A15;
  logic       A14;
  logic       A13;
  logic       A8;
  logic [7:0] D;
  logic       IOREQ_B;
  logic       MREQ_B;
  logic       WR_B;
  logic       ROMEN_B;
  logic       BANK;
  logic [7:0] SLOT_EN;

  logic [3:0] ROMCS_B;
  logic       ROM_A14;
  logic       ROMDIS;
  logic       ROM_WE_B;
  logic       READY_PULL;
  logic       BUSY;
  wr_state_e  STATE_DBG;

  // CPC side: drives the bus and straps, observes the board outputs.
  modport master (
    output A15, A14, A13, A8, D, IOREQ_B, MREQ_B, WR_B, ROMEN_B, BANK, SLOT_EN,
    input  ROMCS_B, ROM_A14, ROMDIS, ROM_WE_B, READY_PULL, BUSY, STATE_DBG
  );

  // Controller side.
  modport slave (
    input  A15, A14, A13, A8, D, IOREQ_B, MREQ_B, WR_B, ROMEN_B, BANK, SLOT_EN,
    output ROMCS_B, ROM_A14, ROMDIS, ROM_WE_B, READY_PULL, BUSY, STATE_DBG
  );
endinterface

// File: rtl/cpc_romctrl_eeprom_wr_seq.sv
// EEPROM byte-write sequencer: WE_B pulse, READY stretch and write-time hold-off.
module eeprom_wr_seq
  import cpc_romctrl_pkg::*;
#(
  parameter int TWC_CYCLES = TWC_CYCLES_DEF,
  parameter int WE_CYCLES  = WE_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      mem_wr_pulse,
  input  logic      hit,
  output logic      rom_we_b,
  output logic      ready_pull,
  output logic      busy,
  output logic      wr_active,
  output wr_state_e state_dbg
);
  localparam int CNT_W = ($clog2(TWC_CYCLES) < 1) ? 1 : $clog2(TWC_CYCLES);
  // The same counter times the WE_B pulse and then the write hold-off.
  localparam logic [CNT_W-1:0] TWC_LOAD = CNT_W'(TWC_CYCLES - 1);
  localparam logic [CNT_W-1:0] WE_LOAD  = CNT_W'(WE_CYCLES - 1);

  wr_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rom_we_b_q, rom_we_b_d;
  logic             ready_pull_q, ready_pull_d;
  logic             busy_q, busy_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // Next state and counter; outputs are decoded from the next state so they
  // leave flops glitch-free and reset asynchronously with the FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_wr_pulse) begin
          state_d = WE;
          cnt_d   = WE_LOAD;
        end
      end
      WE: begin
        if (cnt_zero) begin
          state_d = HOLD;
          cnt_d   = TWC_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          // A request landing on the last hold cycle can start immediately.
          if (mem_wr_pulse && hit) begin
            state_d = WE;
            cnt_d   = WE_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (mem_wr_pulse) state_d = STALL;
        end
      end
      STALL: begin
        if (cnt_zero) begin
          // The stalled write only proceeds if the current select still hits.
          if (hit) begin
            state_d = WE;
            cnt_d   = WE_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    rom_we_b_d   = (state_d != WE);
    ready_pull_d = (state_d == WE) || (state_d == STALL);
    busy_d       = (state_d == HOLD) || (state_d == STALL);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rom_we_b_q   <= 1'b1;
      ready_pull_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rom_we_b_q   <= rom_we_b_d;
      ready_pull_q <= ready_pull_d;
      busy_q       <= busy_d;
    end
  end

  assign rom_we_b   = rom_we_b_q;
  assign ready_pull = ready_pull_q;
  assign busy       = busy_q;
  assign wr_active  = (state_q == WE);
  assign state_dbg  = state_q;

endmodule

// File: rtl/cpc_romctrl.sv
// CPC eight-slot ROM board controller: I/O-port registers, slot decode and
// the EEPROM write sequencer.
module cpc_romctrl
  import cpc_romctrl_pkg::*;
#(
  parameter int TWC_CYCLES = TWC_CYCLES_DEF,
  parameter int WE_CYCLES  = WE_CYCLES_DEF
) (
  input logic          CLK,
  input logic          RESET_B,
  cpc_romctrl_if.slave bus
);
  logic [7:0] sel_q, sel_d;
  logic [7:0] wr_sel_q, wr_sel_d;
  logic       wen_q, wen_d;
  logic       romdis_q, romdis_d;
  logic       io_wr_q, mem_wr_q;
  logic       io_wr, io_wr_pulse;
  logic       mem_wr, mem_wr_pulse;
  logic       hit, cs_hit;
  logic [7:0] cs_sel;
  logic [3:0] romcs_b;
  logic       wr_active;
  logic       rom_we_b, ready_pull, busy;
  wr_state_e  state_dbg;

  // Bus decode, register writes and chip-select generation.
  always_comb begin
    io_wr       = !bus.IOREQ_B && !bus.WR_B && !bus.A13;
    io_wr_pulse = io_wr && !io_wr_q;

    sel_d = sel_q;
    wen_d = wen_q;
    if (io_wr_pulse) begin
      if (bus.A8 == SEL_PORT_A8) sel_d = bus.D;
      else                       wen_d = bus.D[0];
    end

    hit      = slot_hit(sel_q, bus.BANK, bus.SLOT_EN);
    romdis_d = hit;

    mem_wr = !bus.MREQ_B && !bus.WR_B && bus.A15 && bus.A14 && hit && wen_q;
    // An I/O write in the same cycle wins; the memory write is dropped.
    mem_wr_pulse = mem_wr && !mem_wr_q && !io_wr;

    // Freeze the target slot while WE is low so a select change cannot
    // redirect a write already in flight.
    wr_sel_d = wr_active ? wr_sel_q : sel_q;
    cs_sel   = wr_active ? wr_sel_q : sel_q;
    cs_hit   = wr_active ? slot_hit(wr_sel_q, bus.BANK, bus.SLOT_EN) : hit;

    romcs_b = 4'hF;
    if (cs_hit && bus.A14 && (!bus.ROMEN_B || wr_active)) romcs_b[cs_sel[2:1]] = 1'b0;
  end

  // Port registers and edge-detect history.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      sel_q    <= '0;
      wr_sel_q <= '0;
      wen_q    <= 1'b0;
      romdis_q <= 1'b0;
      io_wr_q  <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      sel_q    <= sel_d;
      wr_sel_q <= wr_sel_d;
      wen_q    <= wen_d;
      romdis_q <= romdis_d;
      io_wr_q  <= io_wr;
      mem_wr_q <= mem_wr;
    end
  end

  eeprom_wr_seq #(
    .TWC_CYCLES(TWC_CYCLES),
    .WE_CYCLES (WE_CYCLES)
  ) u_wr_seq (
    .clk         (CLK),
    .rst_n       (RESET_B),
    .mem_wr_pulse(mem_wr_pulse),
    .hit         (hit),
    .rom_we_b    (rom_we_b),
    .ready_pull  (ready_pull),
    .busy        (busy),
    .wr_active   (wr_active),
    .state_dbg   (state_dbg)
  );

  assign bus.ROMCS_B    = romcs_b;
  assign bus.ROM_A14    = cs_sel[0];
  assign bus.ROMDIS     = romdis_q;
  assign bus.ROM_WE_B   = rom_we_b;
  assign bus.READY_PULL = ready_pull;
  assign bus.BUSY       = busy;
  assign bus.STATE_DBG  = state_dbg;

endmodule

// File: tb/tb_cpc_romctrl.sv
// Directed bench for cpc_romctrl. The driver pushes every expected output
// change (cycle number + output vector) into a queue; a monitor on the
// falling edge pops and compares whenever the output vector changes.
module tb_cpc_romctrl;
  import cpc_romctrl_pkg::*;

  localparam int TWC   = 16;
  localparam int WEC   = 2;
  localparam int VEC_W = 9;
  localparam int EXP_W = 32 + VEC_W;

  // ---------------- clock / reset ----------------
  logic CLK     = 1'b0;
  logic RESET_B = 1'b0;
  int   cyc     = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  cpc_romctrl_if bus();

  cpc_romctrl #(
    .TWC_CYCLES(TWC),
    .WE_CYCLES (WEC)
  ) dut (
    .CLK    (CLK),
    .RESET_B(RESET_B),
    .bus    (bus)
  );

  // Output vector: {ROMCS_B[3:0], ROM_A14, ROMDIS, ROM_WE_B, READY_PULL, BUSY}
  logic [VEC_W-1:0] out_vec;
  assign out_vec = {bus.ROMCS_B, bus.ROM_A14, bus.ROMDIS, bus.ROM_WE_B,
                    bus.READY_PULL, bus.BUSY};

  int n_cmp = 0;
  int n_bad = 0;
  logic [EXP_W-1:0] exp_q[$];

  function automatic logic [VEC_W-1:0] mk(input logic [3:0] cs, input logic a14,
                                          input logic dis, input logic web,
                                          input logic rp, input logic bsy);
    return {cs, a14, dis, web, rp, bsy};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic expect_at(input int c, input logic [VEC_W-1:0] v);
    exp_q.push_back({32'(c), v});
  endtask

  task automatic check_vec(input string name, input logic [VEC_W-1:0] v);
    n_cmp++;
    if (out_vec !== v) begin
      n_bad++;
      $display("FAIL %s got=%b required=%b", name, out_vec, v);
    end
  endtask

  task automatic check_state(input string name, input wr_state_e s);
    n_cmp++;
    if (bus.STATE_DBG !== s) begin
      n_bad++;
      $display("FAIL %s got=%s required=%s", name, bus.STATE_DBG.name(), s.name());
    end
  endtask

  logic [VEC_W-1:0] mon_prev;
  logic [EXP_W-1:0] mon_got, mon_exp;

  // Monitor: every change of the outputs must match the next queued entry.
  initial begin
    @(negedge CLK);
    mon_prev = out_vec;
    forever begin
      @(negedge CLK);
      if (out_vec !== mon_prev) begin
        mon_got = {32'(cyc), out_vec};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b", cyc, out_vec);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_bad++;
            $display("FAIL out_change got cyc=%0d vec=%b required cyc=%0d vec=%b",
                     cyc, out_vec, mon_exp[EXP_W-1:VEC_W], mon_exp[VEC_W-1:0]);
          end
        end
        mon_prev = out_vec;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic io_write(input logic a8, input logic [7:0] d);
    bus.IOREQ_B = 1'b0;
    bus.WR_B    = 1'b0;
    bus.A13     = 1'b0;
    bus.A8      = a8;
    bus.D       = d;
    tick();
    tick();
    bus.IOREQ_B = 1'b1;
    bus.WR_B    = 1'b1;
    bus.A13     = 1'b1;
  endtask

  // Memory write into the &C000 page, strobes held for 'hold' cycles.
  task automatic mem_write(input int hold);
    bus.A15    = 1'b1;
    bus.A13    = 1'b0;
    bus.A8     = 1'b1;
    bus.MREQ_B = 1'b0;
    bus.WR_B   = 1'b0;
    repeat (hold) tick();
    bus.MREQ_B = 1'b1;
    bus.WR_B   = 1'b1;
    bus.A15    = 1'b0;
    bus.A13    = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [VEC_W-1:0] v_reset, v_hit0, v_hit1, v_miss1, v_miss0;
  logic [VEC_W-1:0] v_we, v_hold, v_stall, v_idle;
  int c;

  initial begin
    v_reset = mk(4'hF,    1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    v_hit0  = mk(4'b1011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    v_hit1  = mk(4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    v_miss1 = mk(4'hF,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    v_miss0 = mk(4'hF,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    v_we    = mk(4'b1011, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    v_hold  = mk(4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    v_stall = mk(4'b1011, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    v_idle  = v_hit1;

    bus.A15 = 1'b0; bus.A14 = 1'b0; bus.A13 = 1'b1; bus.A8 = 1'b0; bus.D = 8'h00;
    bus.IOREQ_B = 1'b1; bus.MREQ_B = 1'b1; bus.WR_B = 1'b1; bus.ROMEN_B = 1'b1;
    bus.BANK = 1'b0; bus.SLOT_EN = 8'hFE;   // slot 0 empty: nothing hits after reset
    RESET_B = 1'b0;
    repeat (2) tick();
    check_vec("reset_outputs", v_reset);
    check_state("reset_state", IDLE);
    RESET_B = 1'b1;
    tick();
    bus.A14 = 1'b1;
    bus.ROMEN_B = 1'b0;
    repeat (2) tick();

    // Select slot 5 (pair 45, odd): CS on pair 2, ROMDIS one cycle later.
    c = cyc; expect_at(c + 1, v_hit0); expect_at(c + 2, v_hit1);
    io_write(SEL_PORT_A8, 8'h05); repeat (2) tick();
    // sel=15: upper nibble non-zero, no hit.
    c = cyc; expect_at(c + 1, v_miss1); expect_at(c + 2, v_miss0);
    io_write(SEL_PORT_A8, 8'h15); repeat (2) tick();
    c = cyc; expect_at(c + 1, v_hit0); expect_at(c + 2, v_hit1);
    io_write(SEL_PORT_A8, 8'h05); repeat (2) tick();
    // Unpopulate slot 5: CS drops at once, ROMDIS on the next edge.
    c = cyc; expect_at(c, v_miss1); expect_at(c + 1, v_miss0);
    bus.SLOT_EN = 8'hDE; repeat (3) tick();
    c = cyc; expect_at(c, v_hit0); expect_at(c + 1, v_hit1);
    bus.SLOT_EN = 8'hFE; repeat (3) tick();
    // sel=0D: bank bit 1 against BANK=0, no hit.
    c = cyc; expect_at(c + 1, v_miss1); expect_at(c + 2, v_miss0);
    io_write(SEL_PORT_A8, 8'h0D); repeat (2) tick();
    c = cyc; expect_at(c + 1, v_hit0); expect_at(c + 2, v_hit1);
    io_write(SEL_PORT_A8, 8'h05); repeat (2) tick();

    // Memory write with wen=0: no WE, no READY, no change at all.
    mem_write(3); repeat (4) tick();
    check_state("wen0_ignored", IDLE);

    // Enable writes.
    io_write(CTL_PORT_A8, 8'h01); repeat (2) tick();

    // Single write: WE/READY for 2 cycles, BUSY for 16.
    c = cyc;
    expect_at(c + 1, v_we); expect_at(c + 3, v_hold); expect_at(c + 19, v_idle);
    mem_write(3); repeat (19) tick();

    // Second write 3 cycles into HOLD: STALL until cnt==0, then straight to WE.
    c = cyc;
    expect_at(c + 1, v_we);    expect_at(c + 3, v_hold);  expect_at(c + 7, v_stall);
    expect_at(c + 19, v_we);   expect_at(c + 21, v_hold); expect_at(c + 37, v_idle);
    mem_write(3); repeat (3) tick();
    mem_write(3);
    check_state("stall_entry", STALL);
    repeat (9) tick();
    check_state("stall_last", STALL);
    tick();
    check_state("stall_to_we", WE);
    repeat (22) tick();

    // Stalled write whose select stops hitting: released to IDLE, no WE.
    c = cyc;
    expect_at(c + 1, v_we); expect_at(c + 3, v_hold); expect_at(c + 7, v_stall);
    expect_at(c + 11, mk(4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    expect_at(c + 12, mk(4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    expect_at(c + 19, v_miss0);
    mem_write(3); repeat (3) tick();
    mem_write(3); tick();
    io_write(SEL_PORT_A8, 8'h15);
    repeat (6) tick();
    check_state("stall_miss_wait", STALL);
    tick();
    check_state("stall_miss_idle", IDLE);
    repeat (2) tick();
    c = cyc; expect_at(c + 1, v_hit0); expect_at(c + 2, v_hit1);
    io_write(SEL_PORT_A8, 8'h05); repeat (2) tick();

    // io_wr and mem_wr in the same cycle: only the I/O write is taken.
    bus.IOREQ_B = 1'b0; bus.MREQ_B = 1'b0; bus.WR_B = 1'b0;
    bus.A13 = 1'b0; bus.A8 = 1'b1; bus.A15 = 1'b1; bus.D = 8'h05;
    tick();
    bus.IOREQ_B = 1'b1; bus.MREQ_B = 1'b1; bus.WR_B = 1'b1;
    bus.A13 = 1'b1; bus.A15 = 1'b0;
    repeat (3) tick();
    check_state("simultaneous_ignored", IDLE);

    // Asynchronous reset in the middle of WE.
    c = cyc; expect_at(c + 1, v_we); expect_at(c + 2, v_reset);
    bus.A15 = 1'b1; bus.A13 = 1'b0; bus.MREQ_B = 1'b0; bus.WR_B = 1'b0;
    repeat (2) tick();
    RESET_B = 1'b0;
    #1;
    check_vec("async_reset_we", v_reset);
    check_state("async_reset_state", IDLE);
    bus.MREQ_B = 1'b1; bus.WR_B = 1'b1; bus.A15 = 1'b0; bus.A13 = 1'b1;
    repeat (2) tick();
    RESET_B = 1'b1;
    repeat (4) tick();

    // ---------------- final report ----------------
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL expected_events_left got=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
